// File: rtl/pipe_regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the decode-stage register file with write scoreboard.
package pipe_regfile_scoreboard_pkg;

   localparam int DSIZE_DEF = 32;
   localparam int ASIZE_DEF = 5;
   localparam int NREAD_DEF = 2;
   localparam int CNTW_DEF  = 2;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   function automatic int cnt_max(input int cntw);
      return (1 << cntw) - 1;
   endfunction

   // Low bit of port "port" inside a flattened multi-port bus.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/pipe_regfile_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one register, with an underflow flag.
module pipe_regfile_scoreboard_sb_counter
   import pipe_regfile_scoreboard_pkg::*;
#(
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            dec,
   output logic [CNTW-1:0] cnt,
   output logic            underflow
);

   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(cnt_max(CNTW));

   cnt_op_e         op;
   logic [CNTW-1:0] cnt_d;
   logic [CNTW-1:0] cnt_q;

   always_comb begin
      op = CNT_HOLD;
      if (inc && !dec) begin
         op = CNT_INC;
      end else if (dec && !inc) begin
         op = CNT_DEC;
      end
      cnt_d = cnt_q;
      case (op)
         CNT_INC: if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         CNT_DEC: if (cnt_q != '0)      cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // A retire with nothing outstanding is flagged even if an issue lands in the same cycle.
   assign underflow = dec && (cnt_q == '0);
   assign cnt       = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pipe_regfile_scoreboard.sv
// Register file with NREAD combinational read ports, one write-back port and a RAW scoreboard.
// Define REGFILE_BYPASS_EN for write-through bypass of read data and busy status.
module pipe_regfile_scoreboard
   import pipe_regfile_scoreboard_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int ASIZE = ASIZE_DEF,
   parameter int NREAD = NREAD_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREAD-1:0]       rd_en,
   input  logic [NREAD*ASIZE-1:0] raddr,
   output logic [NREAD*DSIZE-1:0] rdata,
   output logic [NREAD-1:0]       rbusy,
   input  logic                   issue_valid,
   input  logic [ASIZE-1:0]       issue_waddr,
   output logic                   issue_ready,
   input  logic                   wen,
   input  logic [ASIZE-1:0]       waddr,
   input  logic [DSIZE-1:0]       wdata,
   output logic                   stall,
   output logic                   sb_err
);

   localparam int              NREG    = 1 << ASIZE;
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(cnt_max(CNTW));

   logic [DSIZE-1:0] regs_d [NREG];
   logic [DSIZE-1:0] regs_q [NREG];
   logic [CNTW-1:0]  cnt    [NREG];
   logic [NREG-1:0]  dec_vec;
   logic [NREG-1:1]  inc_vec;
   logic [NREG-1:1]  uflow_vec;
   logic             wen_nz;
   logic             sb_err_d;
   logic             sb_err_q;
   logic [ASIZE-1:0] rd_addr;
   logic [DSIZE-1:0] rd_val;
   logic [CNTW-1:0]  rd_cnt;

   assign wen_nz = wen && (waddr != '0);

   always_comb begin
      dec_vec = '0;
      for (int r = 1; r < NREG; r++) begin
         dec_vec[r] = wen_nz && (waddr == ASIZE'(r));
      end
   end

   // A retire on the same address frees a slot, so a full counter can still accept an issue.
   assign issue_ready = !((issue_waddr != '0) && (cnt[issue_waddr] == CNT_MAX)
                          && !dec_vec[issue_waddr]);

   always_comb begin
      inc_vec = '0;
      for (int r = 1; r < NREG; r++) begin
         inc_vec[r] = issue_valid && issue_ready && (issue_waddr == ASIZE'(r));
      end
   end

   assign cnt[0] = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      pipe_regfile_scoreboard_sb_counter #(
         .CNTW (CNTW)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc_vec[r]),
         .dec       (dec_vec[r]),
         .cnt       (cnt[r]),
         .underflow (uflow_vec[r])
      );
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         regs_d[r] = regs_q[r];
      end
      if (wen_nz) begin
         regs_d[waddr] = wdata;
      end
   end

   assign sb_err_d = sb_err_q || (|uflow_vec);
   assign sb_err   = sb_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
         sb_err_q <= sb_err_d;
      end
   end

   always_comb begin
      rdata   = '0;
      rbusy   = '0;
      rd_addr = '0;
      rd_val  = '0;
      rd_cnt  = '0;
      for (int i = 0; i < NREAD; i++) begin
         rd_addr = raddr[slice_lo(i, ASIZE) +: ASIZE];
         rd_val  = '0;
         rd_cnt  = '0;
         if (rd_addr != '0) begin
            rd_val = regs_q[rd_addr];
            rd_cnt = cnt[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (dec_vec[rd_addr]) begin
               rd_val = wdata;
               if (rd_cnt != '0) rd_cnt = rd_cnt - 1'b1;
            end
`endif
         end
         rdata[slice_lo(i, DSIZE) +: DSIZE] = rd_val;
         rbusy[i]                           = (rd_cnt != '0);
      end
   end

   assign stall = (|(rd_en & rbusy)) || (issue_valid && !issue_ready);

endmodule

// File: tb/tb_pipe_regfile_scoreboard.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic vs a model.
module tb_pipe_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   rd_en;
   logic [19:0]  raddr;
   logic [127:0] rdata;
   logic [3:0]   rbusy;
   logic         issue_valid;
   logic [4:0]   issue_waddr;
   logic         issue_ready;
   logic         wen;
   logic [4:0]   waddr;
   logic [31:0]  wdata;
   logic         stall;
   logic         sb_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_reg  [32];
   int          m_pend [32];
   bit          m_err;

   pipe_regfile_scoreboard #(
      .DSIZE (32),
      .ASIZE (5),
      .NREAD (4),
      .CNTW  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .raddr       (raddr),
      .rdata       (rdata),
      .rbusy       (rbusy),
      .issue_valid (issue_valid),
      .issue_waddr (issue_waddr),
      .issue_ready (issue_ready),
      .wen         (wen),
      .waddr       (waddr),
      .wdata       (wdata),
      .stall       (stall),
      .sb_err      (sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  iw;
      logic [19:0] ra;
      logic [3:0]  re;
      logic [31:0] e_rd0;
      logic [3:0]  e_busy;
      logic        e_rdy;
      logic        e_stall;
      logic        e_err;
   } vec_t;

   vec_t tbl [20];

   function automatic logic [19:0] ra4(input int a0, input int a1, input int a2, input int a3);
      return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
   endfunction

   function automatic vec_t mk(input int r, input int we, input int wa, input logic [31:0] wd,
                               input int iv, input int iw, input logic [19:0] ra, input int re,
                               input logic [31:0] rd0, input int busy, input int rdy,
                               input int st, input int er);
      vec_t v;
      v.rst = 1'(r);   v.wen = 1'(we);  v.wa = 5'(wa);   v.wd = wd;
      v.iv = 1'(iv);   v.iw = 5'(iw);   v.ra = ra;       v.re = 4'(re);
      v.e_rd0 = rd0;   v.e_busy = 4'(busy); v.e_rdy = 1'(rdy);
      v.e_stall = 1'(st); v.e_err = 1'(er);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_dec(input int a);
      return wen && (a != 0) && (int'(waddr) == a);
   endfunction

   function automatic bit m_ready();
      int iw;
      iw = int'(issue_waddr);
      return !((iw != 0) && (m_pend[iw] == 3) && !m_dec(iw));
   endfunction

   function automatic int m_eff(input int a);
      if (BYP && m_dec(a) && m_pend[a] > 0) return m_pend[a] - 1;
      return m_pend[a];
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_reg[r]  = '0;
         m_pend[r] = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic check_model();
      logic [3:0]  eb;
      logic [31:0] er;
      int          a;
      eb = '0;
      for (int i = 0; i < 4; i++) begin
         a  = int'(raddr[i*5 +: 5]);
         er = '0;
         if (a != 0) begin
            er = m_reg[a];
            if (BYP && m_dec(a)) er = wdata;
            eb[i] = (m_eff(a) != 0);
         end
         chk($sformatf("rdata%0d", i), rdata[i*32 +: 32], er);
      end
      chk("rbusy", 32'(rbusy), 32'(eb));
      chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
      chk("stall", 32'(stall), 32'((|(rd_en & eb)) || (issue_valid && !m_ready())));
      chk("sb_err", 32'(sb_err), 32'(m_err));
   endtask

   task automatic model_update();
      bit rdy, inc, dec;
      int iw, wa;
      if (rst) begin
         model_reset();
      end else begin
         rdy = m_ready();
         iw  = int'(issue_waddr);
         wa  = int'(waddr);
         inc = issue_valid && rdy && (iw != 0);
         dec = wen && (wa != 0);
         if (dec) m_reg[wa] = wdata;
         if (dec && m_pend[wa] == 0) m_err = 1'b1;
         if (!(inc && dec && iw == wa)) begin
            if (inc) m_pend[iw] = m_pend[iw] + 1;
            if (dec && m_pend[wa] > 0) m_pend[wa] = m_pend[wa] - 1;
         end
      end
   endtask

   task automatic step();
      #2;
      check_model();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic idle();
      rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
      issue_valid = 1'b0; issue_waddr = '0; raddr = '0; rd_en = '0;
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; wen = v.wen; waddr = v.wa; wdata = v.wd;
      issue_valid = v.iv; issue_waddr = v.iw; raddr = v.ra; rd_en = v.re;
   endtask

   initial begin
      tbl[0]  = mk(0,0,0,0,            0,0, ra4(5,0,0,0), 0, 0,0,1,0,0);
      tbl[1]  = mk(0,0,0,0,            1,5, ra4(5,0,0,0), 1, 0,0,1,0,0);
      tbl[2]  = mk(0,1,5,32'hDEADBEEF, 0,0, ra4(5,0,0,0), 1,
                   BYP ? 32'hDEADBEEF : 32'h0, BYP ? 0 : 1, 1, BYP ? 0 : 1, 0);
      tbl[3]  = mk(0,0,0,0,            0,0, ra4(5,0,0,0), 1, 32'hDEADBEEF,0,1,0,0);
      tbl[4]  = mk(0,1,0,32'h1234,     0,0, ra4(0,0,0,0), 1, 0,0,1,0,0);
      tbl[5]  = mk(0,0,0,0,            0,0, ra4(0,0,0,0), 1, 0,0,1,0,0);
      tbl[6]  = mk(0,0,0,0,            1,3, ra4(3,0,0,0), 0, 0,0,1,0,0);
      tbl[7]  = mk(0,0,0,0,            1,3, ra4(3,0,0,0), 0, 0,1,1,0,0);
      tbl[8]  = mk(0,0,0,0,            1,3, ra4(3,0,0,0), 0, 0,1,1,0,0);
      tbl[9]  = mk(0,0,0,0,            1,3, ra4(3,0,0,0), 0, 0,1,0,1,0);
      tbl[10] = mk(0,1,3,32'd33,       1,3, ra4(3,0,0,0), 0, BYP ? 32'd33 : 32'd0,1,1,0,0);
      tbl[11] = mk(0,0,0,0,            0,0, ra4(3,0,0,0), 1, 32'd33,1,1,1,0);
      tbl[12] = mk(0,1,9,32'd99,       0,0, ra4(9,0,0,0), 1, BYP ? 32'd99 : 32'd0,0,1,0,0);
      tbl[13] = mk(0,0,0,0,            0,0, ra4(9,0,0,0), 1, 32'd99,0,1,0,1);
      tbl[14] = mk(1,0,0,0,            0,0, ra4(0,0,0,0), 0, 0,0,1,0,1);
      tbl[15] = mk(0,0,0,0,            1,2, ra4(1,2,3,0), 4'b0010, 0,0,1,0,0);
      tbl[16] = mk(0,0,0,0,            0,0, ra4(1,2,3,0), 4'b0010, 0,4'b0010,1,1,0);
      tbl[17] = mk(0,0,0,0,            0,0, ra4(1,2,3,0), 4'b1101, 0,4'b0010,1,0,0);
      tbl[18] = mk(0,1,2,32'd7,        0,0, ra4(1,2,3,0), 4'b0010,
                   0, BYP ? 0 : 4'b0010, 1, BYP ? 0 : 1, 0);
      tbl[19] = mk(0,0,0,0,            0,0, ra4(1,2,3,0), 4'b0010, 0,0,1,0,0);

      idle();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      for (int a = 0; a < 32; a++) begin
         raddr = ra4(a, 31 - a, a, 0);
         rd_en = 4'hF;
         step();
      end

      for (int k = 0; k < 20; k++) begin
         drive(tbl[k]);
         #2;
         chk($sformatf("tbl%0d_rdata0", k), rdata[31:0], tbl[k].e_rd0);
         chk($sformatf("tbl%0d_rbusy", k), 32'(rbusy), 32'(tbl[k].e_busy));
         chk($sformatf("tbl%0d_ready", k), 32'(issue_ready), 32'(tbl[k].e_rdy));
         chk($sformatf("tbl%0d_stall", k), 32'(stall), 32'(tbl[k].e_stall));
         chk($sformatf("tbl%0d_sb_err", k), 32'(sb_err), 32'(tbl[k].e_err));
         step();
      end

      // RAW hazard on r7 resolved by its write-back.
      idle();
      issue_valid = 1'b1; issue_waddr = 5'd7; raddr = ra4(7,0,0,0); rd_en = 4'b0001;
      step();
      issue_valid = 1'b0; issue_waddr = '0;
      #2; chk("raw_stall_pending", 32'(stall), 32'd1);
      step();
      wen = 1'b1; waddr = 5'd7; wdata = 32'hCAFE0007;
      #2; chk("raw_stall_retire", 32'(stall), BYP ? 32'd0 : 32'd1);
      step();
      wen = 1'b0;
      #2; chk("raw_stall_after", 32'(stall), 32'd0);
      chk("raw_rdata_after", rdata[31:0], 32'hCAFE0007);
      step();

      for (int n = 0; n < 600; n++) begin
         int a;
         idle();
         rst         = ($urandom_range(99) == 0);
         raddr       = ra4($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
         rd_en       = 4'($urandom_range(15));
         issue_valid = ($urandom_range(1) == 1);
         issue_waddr = 5'($urandom_range(7));
         a           = $urandom_range(7);
         waddr       = 5'(a);
         wdata       = $urandom;
         wen         = ((m_pend[a] > 0) && ($urandom_range(99) < 70)) || ($urandom_range(99) < 3);
         if (wen && issue_valid && (int'(issue_waddr) == a) && (a != 0) && (m_pend[a] == 0))
            issue_valid = 1'b0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
